instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Pipeline IF stage; the initiator side of imem. Owns the PC and drives imem_addr.
//  Registers the returned word into the IF/ID pipeline register.
//  Obeys stall and branch-redirect requests from later stages.
//  Halts on a branch-to-self or when the PC leaves imem range.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  IMEM_WORDS  64             imem depth in words; a PC >= 4*IMEM_WORDS is out of range
//  HALT_INSTR  32'hEAFF_FFFE  encoding of B . (branch-to-self), the end-of-program marker
// PORTS
//  clk          in   1   clock; all state changes on posedge
//  rst          in   1   synchronous reset, active-high
//  stall_f      in   1   hazard unit: hold PC and IF/ID contents
//  br_taken     in   1   redirect request from EX
//  br_target    in   32  redirect byte address; bits[1:0] forced to 0
//  imem_addr    out  32  = pc_f, combinational
//  imem_instr   in   32  word from imem, valid in the same cycle as imem_addr
//  pc_f         out  32  current fetch PC
//  if_id_instr  out  32  registered instruction
//  if_id_pc     out  32  PC of if_id_instr
//  if_id_pc8    out  32  if_id_pc+8 (ARM-visible PC)
//  if_id_valid  out  1   1 = if_id_instr is a real fetch; 0 = bubble
//  halted       out  1   1 while in state HALT
// BEHAVIOUR
//  Reset values (rst high at posedge):
//   - pc_f=RESET_PC; if_id_instr=NOP_INSTR; if_id_pc=0; if_id_pc8=8
//   - if_id_valid=0; halted=0; state=RUN
//  Latency: the word at pc_f appears on if_id_* after exactly 1 clock edge.
//  FSM states: RUN, HALT. Per-edge priority in RUN is rst > br_taken > stall_f > normal.
//   - br_taken=1:
//     pc_f <= {br_target[31:2],2'b00}; IF/ID <= bubble (instr=NOP_INSTR, valid=0).
//     Applies even when stall_f=1 (redirect overrides stall).
//   - stall_f=1, br_taken=0:
//     pc_f and all if_id_* hold their values; no state change.
//   - normal, pc_f in range:
//     IF/ID <= {imem_instr, pc_f, pc_f+8, valid=1}; pc_f <= pc_f+4 (32-bit, modulo wrap).
//     If imem_instr==HALT_INSTR, the HALT_INSTR word is still latched with valid=1,
//     pc_f holds, and state -> HALT.
//   - normal, pc_f out of range (pc_f >= 4*IMEM_WORDS):
//     IF/ID <= bubble; pc_f holds; state -> HALT.
//  HALT:
//   - halted=1; pc_f frozen; IF/ID <= bubble every edge.
//   - br_taken and stall_f are ignored; only rst exits HALT.
//  Bubble: if_id_pc and if_id_pc8 keep their prior values (don't-care, but stable).
//  rst mid-stall or mid-redirect: reset values win on that edge.
//  imem_addr has no registered path: a change of pc_f is visible to imem in the same cycle.
// STRUCTURE
//  cpu_pkg (shared):
//   - NOP_INSTR = 32'hE1A0_0000 (MOV r0,r0)
//   - typedef enum logic {FS_RUN, FS_HALT} fetch_state_t
//   - typedef struct packed {instr, pc, pc8, valid} if_id_t, reused by the decode stage
//  Sub-module pc_reg: 32-bit register with sync reset value, load enable and load data.
//  Next-PC mux, halt FSM and IF/ID register stay in instr_fetch.
// TESTING
//  T1 Straight-line fetch:
//     rst for 2 cycles, then release; imem[0..3] = distinct words A,B,C,D, no stall or branch.
//     -> pc_f = 0,4,8,12 on successive cycles.
//     -> if_id_instr = A,B,C one cycle behind, valid=1; if_id_pc8 = 8,12,16.
//  T2 Stall:
//     stall_f=1 for 3 cycles while pc_f=8.
//     -> pc_f stays 8; if_id_* unchanged.
//     -> on release, if_id_instr=C and pc_f=12.
//  T3 Redirect:
//     br_taken=1 with br_target=32'h23 at pc_f=12, stall_f=1 on the same edge.
//     -> pc_f=32'h20; if_id_valid=0; if_id_instr=NOP_INSTR.
//     -> next edge: if_id_instr=imem[8], valid=1.
//  T4 Halt on branch-to-self:
//     imem[5]=HALT_INSTR.
//     -> if_id_instr=HALT_INSTR with valid=1, then halted=1 and pc_f frozen at 20.
//     -> bubbles every edge after; br_taken=1 target 0 has no effect.
//  T5 Out of range and reset:
//     br_target=252, imem[63] ordinary.
//     -> imem[63] fetched valid, then pc_f=256 -> halted=1 with a bubble.
//     -> rst=1 one cycle: pc_f=RESET_PC, halted=0, if_id_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants used by the fetch and decode stages.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  typedef enum logic {FS_RUN, FS_HALT} fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// 32-bit program counter register with synchronous reset value and load enable.
module pc_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= RESET_VAL;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/instr_fetch.sv
// Pipeline IF stage: owns the PC, fetches from imem, fills the IF/ID register,
// honours stall/redirect, and halts on branch-to-self or an out-of-range PC.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64,
  parameter logic [31:0] HALT_INSTR = 32'hEAFF_FFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc_f,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc8,
  output logic        if_id_valid,
  output logic        halted
);

  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

  fetch_state_t state, state_n;
  if_id_t       ifid, ifid_n, bubble;
  logic         pc_ld;
  logic [31:0]  pc_d;

  pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .load (pc_ld),
    .d    (pc_d),
    .q    (pc_f)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FS_RUN;
      ifid.instr <= NOP_INSTR;
      ifid.pc    <= '0;
      ifid.pc8   <= 32'd8;
      ifid.valid <= 1'b0;
    end else begin
      state <= state_n;
      ifid  <= ifid_n;
    end
  end

  // A bubble keeps the previous pc/pc8 so they stay stable while invalid.
  always_comb begin
    bubble       = ifid;
    bubble.instr = NOP_INSTR;
    bubble.valid = 1'b0;
  end

  always_comb begin
    state_n = state;
    ifid_n  = ifid;
    pc_ld   = 1'b0;
    pc_d    = pc_f;
    unique case (state)
      FS_RUN: begin
        if (br_taken) begin
          pc_ld  = 1'b1;
          pc_d   = br_target & ~32'h3;
          ifid_n = bubble;
        end else if (!stall_f) begin
          if (pc_f >= PC_LIMIT) begin
            ifid_n  = bubble;
            state_n = FS_HALT;
          end else begin
            ifid_n.instr = imem_instr;
            ifid_n.pc    = pc_f;
            ifid_n.pc8   = pc_f + 32'd8;
            ifid_n.valid = 1'b1;
            if (imem_instr == HALT_INSTR) begin
              state_n = FS_HALT;
            end else begin
              pc_ld = 1'b1;
              pc_d  = pc_f + 32'd4;
            end
          end
        end
      end
      FS_HALT: ifid_n = bubble;
      default: state_n = FS_RUN;
    endcase
  end

  assign imem_addr   = pc_f;
  assign if_id_instr = ifid.instr;
  assign if_id_pc    = ifid.pc;
  assign if_id_pc8   = ifid.pc8;
  assign if_id_valid = ifid.valid;
  assign halted      = (state == FS_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then random stall/branch/reset
// traffic, compared each edge against a behavioural model of the fetch stage.
module tb_instr_fetch;

  localparam logic [31:0] NOP  = 32'hE1A0_0000;
  localparam logic [31:0] HALT = 32'hEAFF_FFFE;

  logic        clk = 1'b0;
  logic        rst = 1'b0, stall_f = 1'b0, br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] imem_addr, imem_instr, pc_f;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc8;
  logic        if_id_valid, halted;

  logic [31:0] mem [64];
  int errors = 0;
  int checks = 0;

  // model state
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc8;
  logic        m_valid, m_halted;

  instr_fetch #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (64),
    .HALT_INSTR (32'hEAFF_FFFE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_f     (stall_f),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .pc_f        (pc_f),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc8   (if_id_pc8),
    .if_id_valid (if_id_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr < 32'd256)
      imem_instr = mem[int'(imem_addr >> 2)];
    else
      imem_instr = 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("pc_f", pc_f, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    if (m_valid) begin
      check("if_id_pc", if_id_pc, m_ipc);
      check("if_id_pc8", if_id_pc8, m_ipc8);
    end
  endtask

  // One clock edge: drive inputs, advance the model by the stage rules, check after the edge.
  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t);
    logic [31:0] w;
    rst = r; stall_f = s; br_taken = b; br_target = t;
    if (r) begin
      m_pc = 32'h0; m_instr = NOP; m_ipc = 0; m_ipc8 = 8; m_valid = 0; m_halted = 0;
    end else if (m_halted) begin
      m_instr = NOP; m_valid = 0;
    end else if (b) begin
      m_pc = {t[31:2], 2'b00}; m_instr = NOP; m_valid = 0;
    end else if (!s) begin
      if (m_pc >= 32'd256) begin
        m_instr = NOP; m_valid = 0; m_halted = 1;
      end else begin
        w = mem[m_pc / 4];
        m_instr = w; m_ipc = m_pc; m_ipc8 = m_pc + 8; m_valid = 1;
        if (w == HALT) m_halted = 1;
        else m_pc = m_pc + 4;
      end
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    mem[0] = 32'hA000_000A; mem[1] = 32'hB000_000B;
    mem[2] = 32'hC000_000C; mem[3] = 32'hD000_000D;
    mem[5] = HALT;
    @(negedge clk);

    // T1 reset then straight-line fetch
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("rst_pc", pc_f, 32'h0);
    check("rst_instr", if_id_instr, NOP);
    check("rst_pc8", if_id_pc8, 32'd8);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    cyc(0, 0, 0, 0);
    check("t1_instrA", if_id_instr, 32'hA000_000A);
    check("t1_pc", pc_f, 32'd4);
    cyc(0, 0, 0, 0);
    check("t1_instrB", if_id_instr, 32'hB000_000B);
    check("t1_pc8", if_id_pc8, 32'd12);

    // T2 stall at pc 8
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    check("t2_hold_pc", pc_f, 32'd8);
    check("t2_hold_instr", if_id_instr, 32'hB000_000B);
    cyc(0, 0, 0, 0);
    check("t2_rel_instr", if_id_instr, 32'hC000_000C);
    check("t2_rel_pc", pc_f, 32'd12);

    // T3 redirect overrides stall, low bits dropped
    cyc(0, 1, 1, 32'h23);
    check("t3_pc", pc_f, 32'h20);
    check("t3_bubble", if_id_instr, NOP);
    cyc(0, 0, 0, 0);
    check("t3_fetch", if_id_instr, mem[8]);

    // T4 halt on branch-to-self at imem[5]
    cyc(0, 0, 1, 32'd16);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("t4_halt_word", if_id_instr, HALT);
    check("t4_halted", {31'd0, halted}, 32'd1);
    check("t4_pc", pc_f, 32'd20);
    cyc(0, 0, 1, 32'd0);
    cyc(0, 1, 0, 32'd0);
    check("t4_frozen", pc_f, 32'd20);
    check("t4_bubble", {31'd0, if_id_valid}, 32'd0);

    // T5 run off the end of imem, then reset out of halt
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 32'd252);
    cyc(0, 0, 0, 0);
    check("t5_last", if_id_instr, mem[63]);
    check("t5_pc", pc_f, 32'd256);
    cyc(0, 0, 0, 0);
    check("t5_halted", {31'd0, halted}, 32'd1);
    cyc(1, 1, 1, 32'd40);
    check("t5_rst_pc", pc_f, 32'h0);
    check("t5_rst_halt", {31'd0, halted}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT) mem[i] = NOP;
    end
    mem[$urandom_range(20, 60)] = HALT;
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 3),
          ($urandom_range(0, 99) < 25),
          ($urandom_range(0, 99) < 10),
          32'($urandom_range(0, 270)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
